// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: function codes, FSM
// state encoding and a small decode helper.
package calc_pkg;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_MUL = 3'b010;
    localparam logic [2:0] FN_DIV = 3'b011;
    localparam logic [2:0] FN_MOD = 3'b100;
    localparam logic [2:0] FN_SQR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // True for the two functions that go through the iterative divider.
    function automatic logic is_divmod(input logic [2:0] fn);
        return (fn == FN_DIV) || (fn == FN_MOD);
    endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring divider, one quotient bit per clock. The first step is taken on
// the start cycle itself, so RES_W steps complete RES_W-1 clocks after start
// and valid_o rises the cycle after the last step. The divisor must be held
// stable by the caller for the whole run. rst_n or clear_i aborts a run.
module calc_divider #(
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [RES_W-1:0] dividend_i,
    input  logic [RES_W-1:0] divisor_i,
    output logic [RES_W-1:0] quotient_o,
    output logic [RES_W-1:0] remainder_o,
    output logic             valid_o
);

    localparam int CNT_W = $clog2(RES_W) + 1;

    logic [RES_W-1:0] rem_q, rem_d;
    logic [RES_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             valid_q;

    logic [RES_W-1:0] src_rem;
    logic [RES_W-1:0] src_quo;
    logic [RES_W:0]   trial;
    logic [RES_W-1:0] diff;
    logic             bit_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        trial   = {src_rem, src_quo[RES_W-1]};
        diff    = trial[RES_W-1:0] - divisor_i;
        rem_d   = trial[RES_W-1:0];
        bit_d   = 1'b0;
        if (trial >= {1'b0, divisor_i}) begin
            rem_d = diff;
            bit_d = 1'b1;
        end
        quo_d = {src_quo[RES_W-2:0], bit_d};
    end

    // Step sequencing and the completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_i) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= CNT_W'(RES_W - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/calculator_seq.sv
// Sequential push-button calculator with a chained accumulator, a multi-cycle
// divider and a sticky divide-by-zero flag. Optional button lockout is built
// when CALC_BTN_LOCKOUT_EN is defined.
module calculator_seq
    import calc_pkg::*;
#(
    parameter int          IN_W        = 8,
    parameter int          RES_W       = 32,
    parameter int unsigned LOCK_CYCLES = 2097134
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic             clear,
    input  logic [IN_W-1:0]  num1,
    input  logic [IN_W-1:0]  num2,
    input  logic [2:0]       func,
    output logic [RES_W-1:0] cal_result,
    output logic             busy,
    output logic             done,
    output logic             err_div0,
    output logic             report
);

    state_t           state_q;
    logic             btn_q;
    logic [RES_W-1:0] result_q;
    logic [RES_W-1:0] a_q, a_d;
    logic [RES_W-1:0] b_q, b_d;
    logic [2:0]       func_q;
    logic             busy_q, done_q, err_q, report_q;

    logic             req;
    logic             lock_ok;
    logic             accept;
    logic             div_start;
    logic [RES_W-1:0] div_quo, div_rem;
    logic             div_valid;

    // Button history keeps sampling through clear so a held button is not re-seen.
    always_ff @(posedge clk) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= button;
    end

    assign req    = button & ~btn_q;
    assign accept = (state_q == S_IDLE) && req && lock_ok && !clear;

`ifdef CALC_BTN_LOCKOUT_EN
    logic [31:0] lock_cnt_q;

    // Lockout timer: restarts on each accepted request, saturates when ready.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)                lock_cnt_q <= LOCK_CYCLES;
        else if (accept)                    lock_cnt_q <= '0;
        else if (lock_cnt_q != LOCK_CYCLES) lock_cnt_q <= lock_cnt_q + 32'd1;
    end

    assign lock_ok = (lock_cnt_q == LOCK_CYCLES);
`else
    assign lock_ok = 1'b1;
`endif

    // Operand selection: first op takes the switches, chained ops the accumulator.
    always_comb begin
        a_d = report_q ? result_q : {{(RES_W-IN_W){1'b0}}, num1};
        b_d = {{(RES_W-IN_W){1'b0}}, num2};
        if (func == FN_SQR) begin
            a_d = report_q ? result_q : {{(RES_W-IN_W){1'b0}}, num2};
            b_d = a_d;
        end
    end

    assign div_start = (state_q == S_EXEC) && is_divmod(func_q) && (b_q != '0);

    calc_divider #(.RES_W(RES_W)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .start_i     (div_start),
        .dividend_i  (a_q),
        .divisor_i   (b_q),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .valid_o     (div_valid)
    );

    // Main control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= FN_ADD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            report_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        func_q  <= func;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_divmod(func_q) && (b_q != '0)) begin
                        state_q <= S_DIV;
                    end else begin
                        case (func_q)
                            FN_ADD: begin result_q <= a_q + b_q; report_q <= 1'b1; end
                            FN_SUB: begin result_q <= a_q - b_q; report_q <= 1'b1; end
                            FN_MUL,
                            FN_SQR: begin result_q <= a_q * b_q; report_q <= 1'b1; end
                            FN_DIV,
                            FN_MOD: err_q <= 1'b1;
                            default: ;
                        endcase
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (div_valid) begin
                        result_q <= (func_q == FN_DIV) ? div_quo : div_rem;
                        report_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cal_result = result_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_div0   = err_q;
    assign report     = report_q;

endmodule

// File: tb/tb_calculator_seq.sv
// Scoreboard bench for calculator_seq (IN_W=8, RES_W=32, LOCK_CYCLES=8).
module tb_calculator_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        button = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  num1 = '0;
    logic [7:0]  num2 = '0;
    logic [2:0]  func = '0;
    logic [31:0] cal_result;
    logic        busy, done, err_div0, report;

    calculator_seq #(.IN_W(8), .RES_W(32), .LOCK_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .clear      (clear),
        .num1       (num1),
        .num2       (num2),
        .func       (func),
        .cal_result (cal_result),
        .busy       (busy),
        .done       (done),
        .err_div0   (err_div0),
        .report     (report)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        err;
        logic        rep;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %s: result=%08h err_div0=%0b report=%0b cycle=%0d",
                         e.name, cal_result, err_div0, report, cyc);
                check({e.name, ".result"}, cal_result, e.res);
                check({e.name, ".err_div0"}, {31'd0, err_div0}, {31'd0, e.err});
                check({e.name, ".report"}, {31'd0, report}, {31'd0, e.rep});
                check({e.name, ".latency"}, cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        button = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Queue the expectation for a press issued at this negedge.
    task automatic expect_op(input string name, input logic [31:0] res,
                             input logic err, input logic rep, input int lat);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.err  = err;
        e.rep  = rep;
        e.cyc  = cyc + 1 + lat;
        exp_q.push_back(e);
    endtask

    // One-cycle button pulse, called at a negedge; returns at the next negedge.
    task automatic press(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        func = f;
        num1 = a;
        num2 = b;
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s.timeout: got %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic count_busy(input string name, input int expv);
        int b = 0;
        int n = 0;
        while (!done && n < 80) begin
            if (busy) b++;
            @(negedge clk);
            n++;
        end
        check(name, b, expv);
    endtask

    initial begin
        do_reset();
        check("reset.result", cal_result, 32'h0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.err_div0", {31'd0, err_div0}, 32'd0);
        check("reset.report", {31'd0, report}, 32'd0);

        // Add, then chained sub and square.
        expect_op("add", 32'h38, 1'b0, 1'b1, 1);
        press(3'b000, 8'h25, 8'h13);
        wait_drain("add");
        expect_op("sub_wrap", 32'hFFFF_FFF8, 1'b0, 1'b1, 1);
        press(3'b001, 8'h00, 8'h40);
        wait_drain("sub_wrap");
        expect_op("square_chain", 32'h40, 1'b0, 1'b1, 1);
        press(3'b101, 8'h00, 8'h00);
        wait_drain("square_chain");

        // First-op square, and multiply.
        do_reset();
        expect_op("square_first", 32'd144, 1'b0, 1'b1, 1);
        press(3'b101, 8'h00, 8'd12);
        wait_drain("square_first");
        expect_op("mul_chain", 32'd1440, 1'b0, 1'b1, 1);
        press(3'b010, 8'h00, 8'd10);
        wait_drain("mul_chain");

        // Divide and modulo with full divider latency.
        do_reset();
        expect_op("div", 32'd28, 1'b0, 1'b1, 33);
        press(3'b011, 8'd200, 8'd7);
        count_busy("div.busy_cycles", 33);
        wait_drain("div");
        do_reset();
        expect_op("mod", 32'd4, 1'b0, 1'b1, 33);
        press(3'b100, 8'd200, 8'd7);
        wait_drain("mod");

        // Extra press during DIV is dropped: single done.
        do_reset();
        expect_op("div_drop_press", 32'd28, 1'b0, 1'b1, 33);
        press(3'b011, 8'd200, 8'd7);
        repeat (5) @(negedge clk);
        press(3'b000, 8'd1, 8'd1);
        wait_drain("div_drop_press");
        repeat (3) @(negedge clk);

        // Divide by zero, then recovery.
        expect_op("div0", 32'd28, 1'b1, 1'b1, 1);
        press(3'b011, 8'd0, 8'd0);
        wait_drain("div0");
        check("div0.sticky", {31'd0, err_div0}, 32'd1);
        expect_op("after_div0", 32'd30, 1'b0, 1'b1, 1);
        press(3'b000, 8'd0, 8'd2);
        wait_drain("after_div0");
        expect_op("invalid_func", 32'd30, 1'b0, 1'b1, 1);
        press(3'b110, 8'd0, 8'd9);
        wait_drain("invalid_func");

        // Clear beats a simultaneous press.
        clear = 1'b1;
        press(3'b000, 8'd0, 8'd5);
        clear = 1'b0;
        check("clear_req.result", cal_result, 32'h0);
        check("clear_req.report", {31'd0, report}, 32'd0);
        repeat (4) @(negedge clk);

        // Clear mid-DIV aborts without a done pulse.
        press(3'b011, 8'd200, 8'd7);
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_div.result", cal_result, 32'h0);
        check("clear_div.report", {31'd0, report}, 32'd0);
        check("clear_div.busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Press spacing: 4 clocks and 10 clocks after the first.
        do_reset();
        expect_op("space_first", 32'd3, 1'b0, 1'b1, 1);
        press(3'b000, 8'd1, 8'd2);
        repeat (3) @(negedge clk);
`ifdef CALC_BTN_LOCKOUT_EN
        press(3'b000, 8'd0, 8'd5);
        repeat (5) @(negedge clk);
        expect_op("space_third", 32'd4, 1'b0, 1'b1, 1);
        press(3'b000, 8'd0, 8'd1);
`else
        expect_op("space_second", 32'd8, 1'b0, 1'b1, 1);
        press(3'b000, 8'd0, 8'd5);
        repeat (5) @(negedge clk);
        expect_op("space_third", 32'd9, 1'b0, 1'b1, 1);
        press(3'b000, 8'd0, 8'd1);
`endif
        wait_drain("spacing");

        repeat (5) @(negedge clk);
        check("pending_at_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
